lbl_pixel_fetch: RTL and testbench

- Consumes VGA scan coordinates and fetches label-image bytes from the single-port label block RAM (8-bit data, 16-bit address, 1-cycle synchronous read).
- Expands each byte from RGB332 to 12-bit RGB444 and composites it over the background layer.
- Delivers pixel colour, sync and data-enable signals, all delayed to the same fixed pipeline latency.
- Sits between the VGA timing generator and the VGA output register; it is the read-side client of the label RAM.

---
 rtl/lbl_pkg.sv | 15 +
 rtl/lbl_pixel_fetch_if.sv | 13 +
 rtl/lbl_addr_gen.sv | 69 ++++++
 rtl/lbl_pixel_fetch.sv | 98 +++++++++
 tb/tb_lbl_pixel_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lbl_pkg.sv
// Shared types and helpers for the label pixel fetch path: RGB444 type,
// RGB332 expansion and the fixed pipeline latency.
package lbl_pkg;

    typedef logic [11:0] rgb444_t;

    localparam logic [7:0] TRANSP_KEY_DEF = 8'h00;
    localparam int         PIPE_LAT       = 3;

    // Replicate the top bits so full-scale RGB332 maps to full-scale RGB444.
    function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/lbl_pixel_fetch_if.sv
// Read port of the single-port label block RAM (1-cycle synchronous read).
// ram_data is valid in the cycle after an edge that saw ram_en=1; no backpressure.
interface lbl_pixel_fetch_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_en;
    logic                  ram_we;
    logic [7:0]            ram_data;

    modport master (output ram_addr, output ram_en, output ram_we, input ram_data);
    modport slave  (input ram_addr, input ram_en, input ram_we, output ram_data);
endinterface

// File: rtl/lbl_addr_gen.sv
// Label region detect, frame-synchronous show latch and counter-based
// label RAM address generation (row base + scaled column, no multiplier).
module lbl_addr_gen
    import lbl_pkg::*;
#(
    parameter int LBL_X      = 160,
    parameter int LBL_Y      = 120,
    parameter int LBL_W      = 160,
    parameter int LBL_H      = 120,
    parameter int SCALE_SH   = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  de_i,
    input  logic                  lbl_show,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en
);

    localparam int X_END    = LBL_X + (LBL_W << SCALE_SH);
    localparam int Y_END    = LBL_Y + (LBL_H << SCALE_SH);
    localparam int SUB_MASK = (1 << SCALE_SH) - 1;

    logic [ADDR_WIDTH-1:0] row_base;
    logic                  show_q;
    logic                  in_lbl;
    logic                  frame_start;
    logic                  row_done;
    logic [9:0]            dx;
    logic [9:0]            dy;
    logic [9:0]            col;

    always_comb begin
        in_lbl = de_i
              && ({1'b0, pix_x} >= 11'(LBL_X)) && ({1'b0, pix_x} < 11'(X_END))
              && ({1'b0, pix_y} >= 11'(LBL_Y)) && ({1'b0, pix_y} < 11'(Y_END));
        frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);
        dx  = pix_x - 10'(LBL_X);
        dy  = pix_y - 10'(LBL_Y);
        col = dx >> SCALE_SH;
        // Advance one stored row after the last screen row it covers.
        row_done = in_lbl && (pix_x == 10'(X_END - 1))
                && ((dy & 10'(SUB_MASK)) == 10'(SUB_MASK));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
            show_q   <= 1'b0;
            ram_addr <= '0;
            ram_en   <= 1'b0;
        end else begin
            if (frame_start) begin
                show_q   <= lbl_show;
                row_base <= '0;
            end else if (row_done) begin
                row_base <= row_base + ADDR_WIDTH'(LBL_W);
            end
            if (in_lbl) begin
                ram_addr <= row_base + ADDR_WIDTH'(col);
            end
            ram_en <= in_lbl && show_q;
        end
    end

endmodule

// File: rtl/lbl_pixel_fetch.sv
// Label layer fetch and composite: drives the label RAM read port and
// overlays the expanded label pixel on the background, 3-cycle latency.
module lbl_pixel_fetch
    import lbl_pkg::*;
#(
    parameter int         LBL_X      = 160,
    parameter int         LBL_Y      = 120,
    parameter int         LBL_W      = 160,
    parameter int         LBL_H      = 120,
    parameter int         SCALE_SH   = 1,
    parameter int         ADDR_WIDTH = 16,
    parameter logic [7:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                pix_x,
    input  logic [9:0]                pix_y,
    input  logic                      de_i,
    input  logic                      hsync_i,
    input  logic                      vsync_i,
    input  rgb444_t                   bg_rgb,
    input  logic                      lbl_show,
    lbl_pixel_fetch_if.master         ram,
    output rgb444_t                   rgb_o,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      de_o
);

    // Sideband stages before the output register.
    localparam int SB_DEPTH = PIPE_LAT - 1;

    logic [SB_DEPTH-1:0] de_d;
    logic [SB_DEPTH-1:0] hs_d;
    logic [SB_DEPTH-1:0] vs_d;
    rgb444_t             bg_d [SB_DEPTH];
    logic                act_s2;

    assign ram.ram_we = 1'b0;

    lbl_addr_gen #(
        .LBL_X      (LBL_X),
        .LBL_Y      (LBL_Y),
        .LBL_W      (LBL_W),
        .LBL_H      (LBL_H),
        .SCALE_SH   (SCALE_SH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .de_i     (de_i),
        .lbl_show (lbl_show),
        .ram_addr (ram.ram_addr),
        .ram_en   (ram.ram_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_d    <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
            act_s2  <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                bg_d[i] <= '0;
            end
            rgb_o   <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            de_o    <= 1'b0;
        end else begin
            de_d[0] <= de_i;
            hs_d[0] <= hsync_i;
            vs_d[0] <= vsync_i;
            bg_d[0] <= bg_rgb;
            for (int i = 1; i < SB_DEPTH; i++) begin
                de_d[i] <= de_d[i-1];
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
                bg_d[i] <= bg_d[i-1];
            end
            // ram_en doubles as the S1 label-active flag; RAM data lines up with act_s2.
            act_s2  <= ram.ram_en;
            hsync_o <= hs_d[SB_DEPTH-1];
            vsync_o <= vs_d[SB_DEPTH-1];
            de_o    <= de_d[SB_DEPTH-1];
            if (!de_d[SB_DEPTH-1]) begin
                rgb_o <= '0;
            end else if (act_s2 && (ram.ram_data != TRANSP_KEY)) begin
                rgb_o <= rgb332_to_444(ram.ram_data);
            end else begin
                rgb_o <= bg_d[SB_DEPTH-1];
            end
        end
    end

endmodule

// File: tb/tb_lbl_pixel_fetch.sv
// Scoreboard bench for lbl_pixel_fetch: sparse 640x480 scans, directed
// colour/address/show-latch/blanking vectors and a mid-line async reset.
module tb_lbl_pixel_fetch;
    import lbl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       de_i = 1'b0;
    logic       hsync_i = 1'b0;
    logic       vsync_i = 1'b0;
    rgb444_t    bg_rgb = '0;
    logic       lbl_show = 1'b0;
    rgb444_t    rgb_o;
    logic       hsync_o;
    logic       vsync_o;
    logic       de_o;

    lbl_pixel_fetch_if #(.ADDR_WIDTH(16)) ram_if ();

    lbl_pixel_fetch dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .de_i     (de_i),
        .hsync_i  (hsync_i),
        .vsync_i  (vsync_i),
        .bg_rgb   (bg_rgb),
        .lbl_show (lbl_show),
        .ram      (ram_if.master),
        .rgb_o    (rgb_o),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .de_o     (de_o)
    );

    // clock / label RAM model
    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    always @(posedge clk) begin
        if (ram_if.ram_en) ram_if.ram_data <= mem[ram_if.ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    int checks = 0;
    int failures = 0;
    logic [46:0] exp_q[$];   // {due, rgb, hs, vs, de}
    logic [49:0] addr_q[$];  // {due, chk_addr, en, addr}
    bit show_m = 1'b0;
    bit addr_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic rgb444_t expand(input logic [7:0] d);
        rgb444_t r;
        r[11:9] = d[7:5]; r[8] = d[7];
        r[7:5]  = d[4:2]; r[4] = d[4];
        r[3:2]  = d[1:0]; r[1:0] = d[1:0];
        return r;
    endfunction

    // driver: called at a negedge, leaves at the next negedge
    task automatic px(input int x, input int y, input bit de, input rgb444_t bg,
                      input bit show, input bit hand, input rgb444_t hand_rgb);
        bit inl, act, hs, vs;
        int addr;
        rgb444_t er;
        logic [7:0] d;
        inl  = de && x >= 160 && x < 480 && y >= 120 && y < 360;
        act  = inl && show_m;
        addr = inl ? ((y - 120) >> 1) * 160 + ((x - 160) >> 1) : 0;
        d    = mem[addr];
        hs   = x >= 656 && x < 752;
        vs   = y >= 490 && y < 492;
        if (!de) er = 12'h000;
        else if (act && d != 8'h00) er = expand(d);
        else er = bg;
        if (hand) er = hand_rgb;
        exp_q.push_back({32'(cyc + 3), er, hs, vs, de});
        addr_q.push_back({32'(cyc + 1), inl && addr_ok, act, 16'(addr)});
        if (x == 0 && y == 0) begin
            show_m  = show;
            addr_ok = 1'b1;
        end
        pix_x = 10'(x); pix_y = 10'(y); de_i = de;
        hsync_i = hs; vsync_i = vs; bg_rgb = bg; lbl_show = show;
        @(negedge clk);
    endtask

    // monitor
    initial begin
        logic [46:0] e;
        logic [49:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                chk("ram_we", 32'(ram_if.ram_we), 32'd0);
                while (exp_q.size() > 0 && int'(exp_q[0][46:15]) <= cyc) begin
                    e = exp_q.pop_front();
                    if (int'(e[46:15]) < cyc) chk("rgb_late", 32'(cyc), e[46:15]);
                    else begin
                        chk("rgb_o", 32'(rgb_o), 32'(e[14:3]));
                        chk("hsync_o", 32'(hsync_o), 32'(e[2]));
                        chk("vsync_o", 32'(vsync_o), 32'(e[1]));
                        chk("de_o", 32'(de_o), 32'(e[0]));
                    end
                end
                while (addr_q.size() > 0 && int'(addr_q[0][49:18]) <= cyc) begin
                    a = addr_q.pop_front();
                    if (int'(a[49:18]) < cyc) chk("addr_late", 32'(cyc), a[49:18]);
                    else begin
                        chk("ram_en", 32'(ram_if.ram_en), 32'(a[16]));
                        if (a[17]) chk("ram_addr", 32'(ram_if.ram_addr), 32'(a[15:0]));
                    end
                end
            end
        end
    end

    // directed vectors: x, y, bg, expected rgb (frame 0, label shown)
    typedef struct { int x; int y; rgb444_t bg; rgb444_t rgb; } vec_t;
    vec_t vecs [3] = '{
        '{160, 120, 12'h777, 12'hF00},
        '{162, 120, 12'h777, 12'h0FF},
        '{164, 120, 12'h5A3, 12'h5A3}
    };
    int xs [13] = '{158, 159, 160, 161, 162, 163, 164, 300, 478, 479, 480, 481, 700};

    task automatic frame(input int fno, input bit show0, input int mid_y, input bit mid_show);
        bit sh;
        bit hand;
        rgb444_t bg, hr;
        sh = show0;
        px(0, 0, 1, 12'($urandom), sh, 0, 12'h000);
        if (fno == 0) begin
            px(300, 50, 1, 12'h123, sh, 1, 12'h123);
            px(700, 50, 0, 12'hFFF, sh, 1, 12'h000);
        end
        for (int y = 118; y <= 361; y++) begin
            if (y == mid_y) begin
                sh = mid_show;
                px(0, y, 1, 12'($urandom), sh, 0, 12'h000);
            end
            foreach (xs[i]) begin
                bg = 12'($urandom);
                hand = 1'b0;
                hr = 12'h000;
                if (fno == 0) begin
                    foreach (vecs[k]) begin
                        if (vecs[k].x == xs[i] && vecs[k].y == y) begin
                            bg = vecs[k].bg; hand = 1'b1; hr = vecs[k].rgb;
                        end
                    end
                end
                px(xs[i], y, xs[i] < 640, bg, sh, hand, hr);
            end
        end
        px(700, 490, 0, 12'($urandom), sh, 0, 12'h000);
        px(700, 491, 0, 12'($urandom), sh, 0, 12'h000);
        px(700, 492, 0, 12'($urandom), sh, 0, 12'h000);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rgb_o"}, 32'(rgb_o), 32'd0);
        chk({tag, "_hsync_o"}, 32'(hsync_o), 32'd0);
        chk({tag, "_vsync_o"}, 32'(vsync_o), 32'd0);
        chk({tag, "_de_o"}, 32'(de_o), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_if.ram_en), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_if.ram_addr), 32'd0);
    endtask

    int post_x [12] = '{630, 635, 639, 640, 650, 656, 657, 700, 751, 752, 760, 10};

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 19200; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        mem[0] = 8'hE0;
        mem[1] = 8'h1F;
        mem[2] = 8'h00;

        // clock / reset
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        frame(0, 1'b1, -1, 1'b1);   // label shown, directed colour/transparency
        frame(1, 1'b0, 200, 1'b1);  // raised mid-frame: stays hidden
        frame(2, 1'b1, 200, 1'b0);  // dropped mid-frame: stays visible
        frame(3, 1'b0, -1, 1'b0);   // hidden

        // mid-line reset with non-zero outputs in flight
        for (int x = 300; x < 306; x++) px(x, 10, 1, 12'hABC, 1'b1, 0, 12'h000);
        #2 reset_n = 1'b0;
        #1 chk("midrst_rgb_o", 32'(rgb_o), 32'd0);
        chk("midrst_de_o", 32'(de_o), 32'd0);
        chk("midrst_hsync_o", 32'(hsync_o), 32'd0);
        chk("midrst_ram_en", 32'(ram_if.ram_en), 32'd0);
        exp_q.delete();
        addr_q.delete();
        show_m  = 1'b0;
        addr_ok = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // sync/de latency after release, label hidden until next frame start
        foreach (post_x[i]) px(post_x[i], 11, post_x[i] < 640, 12'($urandom), 1'b1, 0, 12'h000);
        for (int x = 160; x < 171; x++) px(x, 130, 1, 12'($urandom), 1'b1, 0, 12'h000);
        px(0, 0, 1, 12'h456, 1'b1, 0, 12'h000);
        for (int x = 160; x < 171; x++) px(x, 120, 1, 12'($urandom), 1'b1, 0, 12'h000);
        px(479, 120, 1, 12'h321, 1'b1, 0, 12'h000);
        px(700, 120, 0, 12'hFFF, 1'b1, 0, 12'h000);

        repeat (6) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
